// File: rtl/mem_bridge_pkg.sv
// Shared types and default sizes for the cache-to-memory bridge.
// Optional feature macro used across the bundle: WBUF_FWD_EN.
package mem_bridge_pkg;

  localparam int DEF_WBUF_DEPTH = 4;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;

  // Cache-facing side: accept, wait for a bus refill, or pulse completion.
  typedef enum logic [1:0] {
    F_IDLE   = 2'd0,
    F_RDWAIT = 2'd1,
    F_RESP   = 2'd2
  } front_state_t;

  // Bus-facing side: at most one transaction outstanding.
  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_WR   = 2'd1,
    B_RD   = 2'd2
  } back_state_t;

  // One posted write at the default widths.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-write circular buffer. Entries are stored as address/data pairs;
// the head stays in the buffer until the bus acknowledges it, so a write in
// flight is still visible to lookups.
// With WBUF_FWD_EN defined a lookup port compares every valid entry and
// returns the youngest match.
module wbuf_fifo
  import mem_bridge_pkg::*;
#(
  parameter int DEPTH  = DEF_WBUF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              full_o,
  output logic              empty_o
`ifdef WBUF_FWD_EN
  ,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              lookup_hit_o,
  output logic [DATA_W-1:0] lookup_data_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Storage write; contents need no reset because count gates validity.
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_mem[wr_ptr_q] <= push_addr_i;
      data_mem[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign head_addr_o = addr_mem[rd_ptr_q];
  assign head_data_o = data_mem[rd_ptr_q];

`ifdef WBUF_FWD_EN
  // Slot gi holds the entry of age gi (0 = oldest); valid when gi < count.
  logic [DEPTH-1:0]  match_vec;
  logic [DATA_W-1:0] match_data [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      logic [PTR_W-1:0] slot;
      assign slot           = rd_ptr_q + PTR_W'(gi);
      assign match_vec[gi]  = (CNT_W'(gi) < count_q) && (addr_mem[slot] == lookup_addr_i);
      assign match_data[gi] = data_mem[slot];
    end
  endgenerate

  // Scan oldest to youngest so the last (youngest) match wins.
  always_comb begin
    lookup_hit_o  = 1'b0;
    lookup_data_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match_vec[k]) begin
        lookup_hit_o  = 1'b1;
        lookup_data_o = match_data[k];
      end
    end
  end
`endif

endmodule

// File: rtl/mem_bridge.sv
// Cache memory-side port to external bus bridge. Write-backs are posted into
// a small buffer and drained one word per bus transaction; refill reads go to
// the bus, waiting for the buffer to empty so read-after-write order holds.
// Optional feature macro: WBUF_FWD_EN -- reads are answered from the buffer
// on an address hit, and non-matching reads may overtake buffered writes.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int WBUF_DEPTH = DEF_WBUF_DEPTH,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_din,
  output logic [DATA_W-1:0] mem_dout,
  output logic              mem_rdy,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  front_state_t      front_q;
  back_state_t       back_q;
  logic              mem_rdy_q;
  logic [DATA_W-1:0] mem_dout_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;

  logic              wbuf_full;
  logic              wbuf_empty;
  logic [ADDR_W-1:0] wbuf_head_addr;
  logic [DATA_W-1:0] wbuf_head_data;
  logic              wr_accept;
  logic              wr_pop;
  logic              rd_ack;
  logic              rd_pending;

  // Full comes from the registered count, so a pop in the same cycle does
  // not open a slot until the following cycle.
  assign wr_accept  = (front_q == F_IDLE) && mem_wen && !wbuf_full;
  assign wr_pop     = (back_q == B_WR) && bus_req_q && bus_ack;
  assign rd_ack     = (back_q == B_RD) && bus_req_q && bus_ack;
  assign rd_pending = (front_q == F_RDWAIT);

`ifdef WBUF_FWD_EN
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
`endif

  wbuf_fifo #(
    .DEPTH  (WBUF_DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wbuf (
    .clk          (clk),
    .rst          (rst),
    .push_i       (wr_accept),
    .push_addr_i  (mem_addr),
    .push_data_i  (mem_din),
    .pop_i        (wr_pop),
    .head_addr_o  (wbuf_head_addr),
    .head_data_o  (wbuf_head_data),
    .full_o       (wbuf_full),
    .empty_o      (wbuf_empty)
`ifdef WBUF_FWD_EN
    ,
    .lookup_addr_i(mem_addr),
    .lookup_hit_o (fwd_hit),
    .lookup_data_o(fwd_data)
`endif
  );

  // Front FSM: accepts cache requests and produces the one-cycle mem_rdy pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      front_q    <= F_IDLE;
      mem_rdy_q  <= 1'b0;
      mem_dout_q <= '0;
      rd_addr_q  <= '0;
    end else begin
      case (front_q)
        F_IDLE: begin
          mem_rdy_q <= 1'b0;
          if (mem_wen) begin
            // A simultaneous read is dropped; the write takes priority.
            if (!wbuf_full) begin
              mem_rdy_q <= 1'b1;
              front_q   <= F_RESP;
            end
          end else if (mem_ren) begin
`ifdef WBUF_FWD_EN
            if (fwd_hit) begin
              mem_dout_q <= fwd_data;
              mem_rdy_q  <= 1'b1;
              front_q    <= F_RESP;
            end else
`endif
            begin
              rd_addr_q <= mem_addr;
              front_q   <= F_RDWAIT;
            end
          end
        end
        F_RDWAIT: begin
          if (rd_ack) begin
            mem_dout_q <= bus_rdata;
            mem_rdy_q  <= 1'b1;
            front_q    <= F_RESP;
          end
        end
        F_RESP: begin
          // Cache drops its request during this cycle; inputs are not sampled.
          mem_rdy_q <= 1'b0;
          front_q   <= F_IDLE;
        end
        default: begin
          mem_rdy_q <= 1'b0;
          front_q   <= F_IDLE;
        end
      endcase
    end
  end

  // Back FSM: arbitrates between drain and refill, holds the bus payload
  // until acknowledged, then leaves one idle cycle before the next request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      back_q      <= B_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      case (back_q)
        B_IDLE: begin
`ifdef WBUF_FWD_EN
          // Forwarding covers hazards, so a refill may bypass buffered writes.
          if (rd_pending) begin
            back_q     <= B_RD;
            bus_req_q  <= 1'b1;
            bus_we_q   <= 1'b0;
            bus_addr_q <= rd_addr_q;
          end else if (!wbuf_empty) begin
            back_q      <= B_WR;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b1;
            bus_addr_q  <= wbuf_head_addr;
            bus_wdata_q <= wbuf_head_data;
          end
`else
          // Refill waits for an empty buffer to keep read-after-write order.
          if (!wbuf_empty) begin
            back_q      <= B_WR;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b1;
            bus_addr_q  <= wbuf_head_addr;
            bus_wdata_q <= wbuf_head_data;
          end else if (rd_pending) begin
            back_q     <= B_RD;
            bus_req_q  <= 1'b1;
            bus_we_q   <= 1'b0;
            bus_addr_q <= rd_addr_q;
          end
`endif
        end
        B_WR, B_RD: begin
          if (bus_ack) begin
            bus_req_q <= 1'b0;
            back_q    <= B_IDLE;
          end
        end
        default: begin
          bus_req_q <= 1'b0;
          back_q    <= B_IDLE;
        end
      endcase
    end
  end

  assign mem_rdy   = mem_rdy_q;
  assign mem_dout  = mem_dout_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard bench for mem_bridge. Stimulus pushes expected cache responses
// and expected bus transactions into queues; a response monitor and a bus
// responder pop and compare them independently.
module tb_mem_bridge;
  import mem_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_ren = 1'b0;
  logic        mem_wen = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_din = '0;
  logic [31:0] mem_dout;
  logic        mem_rdy;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  mem_bridge #(.WBUF_DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_ren  (mem_ren),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .mem_rdy  (mem_rdy),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_ack  (bus_ack),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    int          lat;
  } resp_t;

  typedef struct {
    bit          we;
    wbuf_entry_t e;
  } bus_t;

  resp_t       exp_resp_q[$];
  bus_t        exp_bus_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          issue_cyc = 0;
  bit          ack_hold = 1'b0;
  bit          stray_ack = 1'b0;
  bit          prev_acked = 1'b0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic [31:0] rdata_val = '0;

  logic [31:0] wa [5] = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1008, 32'h0000_100c, 32'h0000_1010};
  logic [31:0] wd [5] = '{32'ha0a0_0001, 32'ha0a0_0002, 32'ha0a0_0003, 32'ha0a0_0004, 32'ha0a0_0005};

  always @(posedge clk) cyc <= cyc + 1;

  // Both request lines high together is not legal stimulus.
  always @(posedge clk) begin
    assert (!(mem_ren && mem_wen)) else $error("illegal stimulus: mem_ren and mem_wen both high");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic push_bus(input bit we, input logic [31:0] a, input logic [31:0] d);
    bus_t b;
    b.we = we;
    b.e.addr = a;
    b.e.data = d;
    exp_bus_q.push_back(b);
  endtask

  // Issue one cache request and hold it until mem_rdy (bounded).
  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_d, input int exp_lat);
    resp_t r;
    @(negedge clk);
    r.is_read = !wr;
    r.data    = exp_d;
    r.lat     = exp_lat;
    exp_resp_q.push_back(r);
    issue_cyc = cyc;
    mem_wen   = wr;
    mem_ren   = !wr;
    mem_addr  = a;
    mem_din   = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_rdy) break;
    end
    if (!mem_rdy) begin
      checks++;
      errors++;
      $display("FAIL req_timeout actual=no_mem_rdy required=mem_rdy addr=%h", a);
    end
    mem_wen = 1'b0;
    mem_ren = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_bus_q.size() == 0 && !bus_req) break;
    end
    chk("drain_done", 32'(exp_bus_q.size()), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_mem_rdy"},   32'(mem_rdy),   32'd0);
    chk({tag, "_mem_dout"},  mem_dout,       32'd0);
    chk({tag, "_bus_req"},   32'(bus_req),   32'd0);
    chk({tag, "_bus_we"},    32'(bus_we),    32'd0);
    chk({tag, "_bus_addr"},  bus_addr,       32'd0);
    chk({tag, "_bus_wdata"}, bus_wdata,      32'd0);
  endtask

  // Response monitor: every mem_rdy pulse must match the oldest expectation.
  resp_t mon_r;
  always @(negedge clk) begin
    if (rst && mem_rdy) begin
      if (exp_resp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected actual=mem_rdy required=no_response");
      end else begin
        mon_r = exp_resp_q.pop_front();
        if (mon_r.is_read) chk("resp_rdata", mem_dout, mon_r.data);
        if (mon_r.lat >= 0) chk("resp_latency", 32'(cyc - issue_cyc), 32'(mon_r.lat));
      end
    end
  end

  // Bus responder and monitor: acks after ack_delay cycles of bus_req unless
  // held, checks each acknowledged transaction and the following req drop.
  initial begin
    bus_t b;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (prev_acked) begin
        chk("bus_req_drop", 32'(bus_req), 32'd0);
        prev_acked = 1'b0;
      end
      if (stray_ack) begin
        bus_ack   = 1'b1;
        stray_ack = 1'b0;
      end else if (rst && bus_req && !ack_hold) begin
        if (wait_cnt >= ack_delay) begin
          bus_ack    = 1'b1;
          bus_rdata  = rdata_val;
          wait_cnt   = 0;
          prev_acked = 1'b1;
          if (exp_bus_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bus_unexpected actual=we%0d addr=%h required=no_transaction", bus_we, bus_addr);
          end else begin
            b = exp_bus_q.pop_front();
            chk("bus_we", 32'(bus_we), 32'(b.we));
            chk("bus_addr", bus_addr, b.e.addr);
            if (b.we) chk("bus_wdata", bus_wdata, b.e.data);
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    logic [31:0] fwd_exp;
    int          fwd_lat;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_outputs_zero("reset");

    // Single write: rdy one cycle later, then the same word on the bus
    push_bus(1'b1, 32'hace12000, 32'hdeadbeef);
    do_req(1'b1, 32'hace12000, 32'hdeadbeef, 32'h0, 1);
    wait_drain();

    // Five writes with acks withheld: four fill the buffer, the fifth stalls
    // until the first ack and is admitted one cycle after it
    ack_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_bus(1'b1, wa[i], wd[i]);
      do_req(1'b1, wa[i], wd[i], 32'h0, 1);
    end
    push_bus(1'b1, wa[4], wd[4]);
    fork
      do_req(1'b1, wa[4], wd[4], 32'h0, 4);
      begin
        repeat (3) @(posedge clk);
        ack_hold = 1'b0;
      end
    join
    wait_drain();

    // Two writes to one address, then a read of it
    ack_hold  = 1'b1;
    rdata_val = 32'h5a5a5a5a;
    push_bus(1'b1, 32'hace12000, 32'h11111111);
    do_req(1'b1, 32'hace12000, 32'h11111111, 32'h0, 1);
    push_bus(1'b1, 32'hace12000, 32'h22222222);
    do_req(1'b1, 32'hace12000, 32'h22222222, 32'h0, 1);
`ifdef WBUF_FWD_EN
    fwd_exp = 32'h22222222;
    fwd_lat = 1;
`else
    push_bus(1'b0, 32'hace12000, 32'h0);
    fwd_exp = 32'h5a5a5a5a;
    fwd_lat = -1;
`endif
    fork
      do_req(1'b0, 32'hace12000, 32'h0, fwd_exp, fwd_lat);
      begin
        repeat (6) @(posedge clk);
        ack_hold = 1'b0;
      end
    join
    wait_drain();

    // Refill read on an empty buffer, ack after three cycles of bus_req
    ack_delay = 3;
    rdata_val = 32'h12345678;
    push_bus(1'b0, 32'haaaaa000, 32'h0);
    do_req(1'b0, 32'haaaaa000, 32'h0, 32'h12345678, 6);
    wait_drain();
    ack_delay = 0;

    // Reset in the middle of a held bus write
    ack_hold = 1'b1;
    push_bus(1'b1, 32'h00000abc, 32'hfeedface);
    do_req(1'b1, 32'h00000abc, 32'hfeedface, 32'h0, 1);
    for (int i = 0; i < 20; i++) begin
      if (bus_req) break;
      @(negedge clk);
    end
    chk("bus_req_before_reset", 32'(bus_req), 32'd1);
    #2 rst = 1'b0;
    #1 chk_outputs_zero("midreset");
    exp_bus_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    ack_hold  = 1'b0;
    stray_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_req_after_reset", 32'(bus_req), 32'd0);
    end

    // Read of the discarded write's address must come from the bus
    rdata_val = 32'hcafef00d;
    push_bus(1'b0, 32'h00000abc, 32'h0);
    do_req(1'b0, 32'h00000abc, 32'h0, 32'hcafef00d, 3);
    wait_drain();

    repeat (3) @(negedge clk);
    chk("resp_queue_empty", 32'(exp_resp_q.size()), 32'd0);
    chk("bus_queue_empty", 32'(exp_bus_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute guard against a hang anywhere in the sequence.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
